// File: rtl/alu_op_sequencer.sv
// Control stage in front of the structural ALU: decodes a request, holds operands
// through a settle window, then captures result and flags onto a response port.
module alu_op_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    output logic             alu_binv,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [2:0]       rsp_op
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             dec_legal;
    logic [1:0]       dec_sel;
    logic             dec_binv;
    logic             dec_cin;
    logic             carry_op;
    logic             settle_done;

    assign accept      = req_valid & req_ready;
    assign settle_done = (state == SETTLE) && (cnt == '0);
    assign carry_op    = (rsp_op == OP_ADD) || (rsp_op == OP_SUB);

    // Subtract-style ops drive the adder with inverted B plus carry-in (two's complement).
    always_comb begin
        dec_legal = 1'b1;
        dec_sel   = 2'b00;
        dec_binv  = 1'b0;
        dec_cin   = 1'b0;
        case (req_op)
            OP_AND: dec_sel = 2'b00;
            OP_OR:  dec_sel = 2'b01;
            OP_ADD: dec_sel = 2'b10;
            OP_SUB: begin
                dec_sel  = 2'b10;
                dec_binv = 1'b1;
                dec_cin  = 1'b1;
            end
            OP_SLT: begin
                dec_sel  = 2'b11;
                dec_binv = 1'b1;
                dec_cin  = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = dec_legal ? SETTLE : DONE;
            SETTLE:  if (cnt == '0) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags are registered copies of where the FSM is headed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == IDLE);
            rsp_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= 2'b00;
            alu_binv <= 1'b0;
            alu_cin  <= 1'b0;
            cnt      <= '0;
        end else begin
            if (accept && dec_legal) begin
                alu_a    <= req_a;
                alu_b    <= req_b;
                alu_sel  <= dec_sel;
                alu_binv <= dec_binv;
                alu_cin  <= dec_cin;
                cnt      <= CNT_LOAD;
            end else if ((state == SETTLE) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Illegal ops bypass the ALU entirely and answer with a zero result plus err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_op     <= 3'b000;
        end else begin
            if (accept) begin
                rsp_op <= req_op;
                if (!dec_legal) begin
                    rsp_result <= '0;
                    rsp_zero   <= 1'b1;
                    rsp_carry  <= 1'b0;
                    rsp_err    <= 1'b1;
                end
            end else if (settle_done) begin
                rsp_result <= alu_result;
                rsp_zero   <= (alu_result == '0);
                rsp_carry  <= carry_op ? alu_cout : 1'b0;
                rsp_err    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control stage directly upstream of the 32-bit structural ALU and its 4:1 result mux.
- Accepts operation requests (op, A, B) over a valid/ready handshake and decodes op into the mux select pair plus adder B-invert and carry-in.
- Holds operands stable for a fixed settle window so the ripple datapath resolves, then captures the mux output with zero/carry flags and returns it on a valid/ready response port.

Parameters:
- WIDTH, 32, operand/result width.
- SETTLE_CYCLES, 4, clock edges operands are held before the ALU result is sampled; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; registered.
- req_op  in  3  operation code.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- alu_a  out  WIDTH  operand A to ALU; registered.
- alu_b  out  WIDTH  operand B to ALU; registered.
- alu_sel  out  2  result mux select; bit1 = mux1, bit0 = mux2.
- alu_binv  out  1  invert B into adder.
- alu_cin  out  1  adder carry-in.
- alu_result  in  WIDTH  result-mux output from ALU.
- alu_cout  in  1  adder carry-out from ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH  captured result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_carry  out  1  captured carry; ADD/SUB only, else 0.
- rsp_err  out  1  illegal op code.
- rsp_op  out  3  echo of accepted op.

Behaviour:
- Op decode (sel, binv, cin):
  - 000 AND: 00, 0, 0.
  - 001 OR: 01, 0, 0.
  - 010 ADD: 10, 0, 0.
  - 110 SUB: 10, 1, 1.
  - 111 SLT: 11, 1, 1.
  - 011, 100, 101: illegal.
- Reset (async, rst_n low):
  - State goes to IDLE; all registered outputs clear to 0, including req_ready.
  - req_ready rises on the first clk edge after rst_n deasserts.
- States IDLE, SETTLE, DONE; req_ready = 1 only in IDLE.
- IDLE: on req_valid & req_ready at an edge:
  - Legal op: latch alu_a, alu_b, alu_sel, alu_binv, alu_cin and rsp_op; load cnt = SETTLE_CYCLES-1; go to SETTLE.
  - Illegal op: leave alu_* unchanged; set rsp_result = 0, rsp_zero = 1, rsp_carry = 0, rsp_err = 1, rsp_op = req_op; go to DONE.
- SETTLE: each edge, if cnt != 0 then decrement cnt. If cnt == 0:
  - rsp_result <= alu_result; rsp_zero <= (alu_result == 0).
  - rsp_carry <= alu_cout if op is ADD/SUB, else 0; rsp_err <= 0.
  - Go to DONE.
- DONE: rsp_valid = 1. On rsp_ready at an edge, go to IDLE and drop rsp_valid.
  - rsp_* hold stable while rsp_valid is 1 and rsp_ready is 0.
- Latency: acceptance at edge T; result sampled at edge T+SETTLE_CYCLES; rsp_valid high from then on.
  - Earliest next acceptance is edge T+SETTLE_CYCLES+2 (DONE→IDLE edge, then the IDLE accept edge).
- alu_* outputs change only on acceptance of a legal op and stay stable through SETTLE, DONE and IDLE.
- req_valid during SETTLE/DONE is ignored; the requester must hold its request until req_ready.
- Reset mid-operation: the in-flight op is dropped and no response is issued; rsp_valid falls asynchronously.
- Widths: result is WIDTH bits; no sign extension or flag other than zero/carry/err.

Test Plan:
- Reset, then ADD A=0xFFFFFFFF B=0x00000001 with SETTLE_CYCLES=4 and a behavioural ALU model (delay < 4 cycles) → alu_sel=10, binv=0, cin=0; rsp_valid 4 edges after accept; rsp_result=0, rsp_zero=1, rsp_carry=1.
- SUB A=5 B=7, then SLT A=5 B=7 → SUB: sel=10, binv=1, cin=1, result=0xFFFFFFFE, zero=0, carry=0. SLT: sel=11, result=1, carry=0.
- AND 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0. OR of the same operands → 0xFFF0FFF0. carry=0 in both; rsp_op echoes 000/001.
- Illegal op 100 → rsp_valid on the next edge; result=0, zero=1, err=1; alu_* unchanged from the previous op.
- Backpressure: hold rsp_ready=0 for 10 cycles while driving a second req_valid → req_ready stays 0 and rsp_* stay stable. Assert rsp_ready → IDLE, then the second request is accepted.
- Reset asserted mid-SETTLE → rsp_valid=0 and req_ready=0 immediately. After release, req_ready=1 and no stale response appears.
